// File: rtl/psram_arbiter_pkg.sv
// Shared definitions for the PSRAM round-robin arbiter: widths, FSM state
// encoding and the effective-burst-length rule.
package psram_arb_pkg;

   localparam int ADDR_W = 22;
   localparam int DATA_W = 32;
   localparam int BLEN_W = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_XFER  = 2'd2;
   localparam state_t ST_GAP   = 2'd3;

   // A zero-length burst still moves one word, and single accesses are one beat.
   function automatic logic [BLEN_W-1:0] eff_beats(input logic burst_en,
                                                   input logic [BLEN_W-1:0] len);
      if (burst_en && (len != '0)) begin
         return len;
      end
      return BLEN_W'(1);
   endfunction

endpackage

// File: rtl/psram_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface psram_arbiter_if
   import psram_arb_pkg::*;
#(
   parameter int N_REQ = 3
);

   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        req_we;
   logic [N_REQ*ADDR_W-1:0] req_a;
   logic [N_REQ*DATA_W-1:0] req_d;
   logic [N_REQ-1:0]        req_burst_en;
   logic [N_REQ*BLEN_W-1:0] req_burst_len;

   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        rsp_ready;
   logic [DATA_W-1:0]       rsp_data;
   logic [N_REQ-1:0]        rsp_err;

   logic [ADDR_W-1:0]       mc_a;
   logic [DATA_W-1:0]       mc_d;
   logic                    mc_we;
   logic                    mc_rd;
   logic                    mc_burst_en;
   logic [BLEN_W-1:0]       mc_burst_length;
   logic                    mc_ready;
   logic [DATA_W-1:0]       mc_spo;

   modport slave (
      input  req, req_we, req_a, req_d, req_burst_en, req_burst_len,
      input  mc_ready, mc_spo,
      output gnt, rsp_ready, rsp_data, rsp_err,
      output mc_a, mc_d, mc_we, mc_rd, mc_burst_en, mc_burst_length
   );

   modport master (
      output req, req_we, req_a, req_d, req_burst_en, req_burst_len,
      output mc_ready, mc_spo,
      input  gnt, rsp_ready, rsp_data, rsp_err,
      input  mc_a, mc_d, mc_we, mc_rd, mc_burst_en, mc_burst_length
   );

endinterface

// File: rtl/psram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_REQ.
module rr_pick #(
   parameter int N_REQ = 3
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         onehot,
   output logic [$clog2(N_REQ)-1:0] idx,
   output logic                     any
);

   localparam int IDX_W = $clog2(N_REQ);

   always_comb begin
      int j;
      j      = 0;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) begin
            j = j - N_REQ;
         end
         if (!any && req[j]) begin
            any       = 1'b1;
            onehot[j] = 1'b1;
            idx       = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one burst PSRAM controller among N_REQ masters.
// Optional beat watchdog: define PSRAM_ARB_TIMEOUT_EN to enable abort on TIMEOUT.
module psram_arbiter
   import psram_arb_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int GAP   = 2
`ifdef PSRAM_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 1024
`endif
) (
   input  logic           clk_mem,
   input  logic           rst,
   psram_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(N_REQ);

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   g_idx;
   logic [BLEN_W-1:0]  beats;
   logic [31:0]        gap_cnt;
   logic               dir_we;
   logic [N_REQ-1:0]   gnt_q;
   logic [ADDR_W-1:0]  mc_a_q;
   logic               mc_we_q;
   logic               mc_rd_q;
   logic               mc_burst_en_q;
   logic [BLEN_W-1:0]  mc_burst_len_q;

   logic [N_REQ-1:0]   pick_onehot;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               beat_fire;
   logic [IDX_W-1:0]   ptr_next;

   logic [ADDR_W-1:0]  a_arr   [N_REQ];
   logic [DATA_W-1:0]  d_arr   [N_REQ];
   logic [BLEN_W-1:0]  len_arr [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign a_arr[i]   = bus.req_a[i*ADDR_W +: ADDR_W];
      assign d_arr[i]   = bus.req_d[i*DATA_W +: DATA_W];
      assign len_arr[i] = bus.req_burst_len[i*BLEN_W +: BLEN_W];
   end

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req    (bus.req),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Beats are only meaningful while a transfer is in flight; anything else
   // the controller strobes is dropped here.
   assign beat_fire = (state == ST_XFER) && bus.mc_ready;
   assign ptr_next  = (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;

   assign bus.gnt             = gnt_q;
   assign bus.rsp_ready       = beat_fire ? gnt_q : '0;
   assign bus.rsp_data        = beat_fire ? bus.mc_spo : '0;
   assign bus.mc_a            = mc_a_q;
   assign bus.mc_d            = d_arr[g_idx];
   assign bus.mc_we           = mc_we_q;
   assign bus.mc_rd           = mc_rd_q;
   assign bus.mc_burst_en     = mc_burst_en_q;
   assign bus.mc_burst_length = mc_burst_len_q;

`ifdef PSRAM_ARB_TIMEOUT_EN
   logic [31:0]      wait_cnt;
   logic [N_REQ-1:0] err_q;
   assign bus.rsp_err = err_q;
`else
   assign bus.rsp_err = '0;
`endif

   // Single FSM: grant snapshot in IDLE, one-cycle command in ISSUE, beat
   // counting in XFER, then a fixed recovery gap before the pointer advances.
   always_ff @(posedge clk_mem) begin
      if (rst) begin
         state          <= ST_IDLE;
         ptr            <= '0;
         g_idx          <= '0;
         beats          <= '0;
         gap_cnt        <= '0;
         dir_we         <= 1'b0;
         gnt_q          <= '0;
         mc_a_q         <= '0;
         mc_we_q        <= 1'b0;
         mc_rd_q        <= 1'b0;
         mc_burst_en_q  <= 1'b0;
         mc_burst_len_q <= '0;
`ifdef PSRAM_ARB_TIMEOUT_EN
         wait_cnt       <= '0;
         err_q          <= '0;
`endif
      end else begin
         mc_we_q <= 1'b0;
         mc_rd_q <= 1'b0;
`ifdef PSRAM_ARB_TIMEOUT_EN
         err_q   <= '0;
`endif
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  gnt_q          <= pick_onehot;
                  g_idx          <= pick_idx;
                  mc_a_q         <= a_arr[pick_idx];
                  dir_we         <= bus.req_we[pick_idx];
                  mc_burst_en_q  <= bus.req_burst_en[pick_idx];
                  mc_burst_len_q <= eff_beats(bus.req_burst_en[pick_idx], len_arr[pick_idx]);
                  beats          <= eff_beats(bus.req_burst_en[pick_idx], len_arr[pick_idx]);
                  state          <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               mc_we_q <= dir_we;
               mc_rd_q <= ~dir_we;
               state   <= ST_XFER;
`ifdef PSRAM_ARB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            ST_XFER: begin
               if (bus.mc_ready) begin
                  beats <= beats - 1'b1;
`ifdef PSRAM_ARB_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
                  if (beats <= BLEN_W'(1)) begin
                     gap_cnt <= '0;
                     state   <= ST_GAP;
                  end
               end
`ifdef PSRAM_ARB_TIMEOUT_EN
               else if (wait_cnt == 32'(TIMEOUT - 1)) begin
                  err_q   <= gnt_q;
                  gap_cnt <= '0;
                  state   <= ST_GAP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            ST_GAP: begin
               if (gap_cnt == 32'(GAP - 1)) begin
                  ptr   <= ptr_next;
                  gnt_q <= '0;
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_psram_arbiter;
   import psram_arb_pkg::*;

   localparam int N  = 3;
   localparam int G  = 2;
   localparam int TO = 16;

   logic clk_mem = 1'b0;
   logic rst     = 1'b1;

   always #5 clk_mem = ~clk_mem;

   psram_arbiter_if #(.N_REQ(N)) bus ();

   psram_arbiter #(
      .N_REQ (N),
      .GAP   (G)
`ifdef PSRAM_ARB_TIMEOUT_EN
      ,
      .TIMEOUT (TO)
`endif
   ) dut (
      .clk_mem (clk_mem),
      .rst     (rst),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model: tracks who owns the controller and which phase of the
   // transaction it is in, derived from the grant/issue/beat/gap rules.
   int               m_owner = -1;
   int               m_phase = 0;
   int               m_beats_left = 0;
   int               m_gap_left = 0;
   int               m_ptr = 0;
   int               m_idle_beats = 0;
   bit               m_dir_we = 0;
   bit               m_rd_pulse = 0;
   bit               m_we_pulse = 0;
   logic [21:0]      m_a = '0;
   bit               m_ben = 0;
   logic [7:0]       m_blen = '0;
   logic [N-1:0]     m_err = '0;
   bit               m_valid = 0;

   always @(posedge clk_mem) begin : model
      int pick;
      int len;
      m_valid    = 1;
      m_rd_pulse = 0;
      m_we_pulse = 0;
      m_err      = '0;
      if (rst) begin
         m_owner = -1; m_phase = 0; m_beats_left = 0; m_ptr = 0;
         m_dir_we = 0; m_a = '0; m_ben = 0; m_blen = '0;
      end else if (m_phase == 0) begin
         pick = -1;
         for (int k = 0; k < N; k++)
            if (pick < 0 && bus.req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
         if (pick >= 0) begin
            m_owner  = pick;
            m_dir_we = bus.req_we[pick];
            m_a      = bus.req_a[pick*22 +: 22];
            m_ben    = bus.req_burst_en[pick];
            len      = int'(bus.req_burst_len[pick*8 +: 8]);
            m_beats_left = (m_ben && len > 0) ? len : 1;
            m_blen   = 8'(m_beats_left);
            m_phase  = 1;
         end
      end else if (m_phase == 1) begin
         m_rd_pulse   = !m_dir_we;
         m_we_pulse   = m_dir_we;
         m_idle_beats = 0;
         m_phase      = 2;
      end else if (m_phase == 2) begin
         if (bus.mc_ready) begin
            m_beats_left--;
            m_idle_beats = 0;
            if (m_beats_left == 0) begin m_phase = 3; m_gap_left = G; end
         end else begin
`ifdef PSRAM_ARB_TIMEOUT_EN
            m_idle_beats++;
            if (m_idle_beats == TO) begin
               m_err[m_owner] = 1'b1;
               m_phase = 3; m_gap_left = G;
            end
`endif
         end
      end else begin
         m_gap_left--;
         if (m_gap_left == 0) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_phase = 0;
         end
      end
   end

   always @(negedge clk_mem) begin : compare
      logic [N-1:0] e_gnt;
      logic [N-1:0] e_rdy;
      if (m_valid) begin
         e_gnt = '0;
         e_rdy = '0;
         if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
         if (m_phase == 2 && bus.mc_ready) e_rdy = e_gnt;
         check_output("gnt", bus.gnt, e_gnt);
         check_output("mc_rd", bus.mc_rd, m_rd_pulse);
         check_output("mc_we", bus.mc_we, m_we_pulse);
         check_output("mc_a", bus.mc_a, m_a);
         check_output("mc_burst_en", bus.mc_burst_en, m_ben);
         check_output("mc_burst_length", bus.mc_burst_length, m_blen);
         check_output("rsp_ready", bus.rsp_ready, e_rdy);
         check_output("rsp_err", bus.rsp_err, m_err);
         if (e_rdy != '0 && !m_dir_we)
            check_output("rsp_data", bus.rsp_data, bus.mc_spo);
         if (m_owner >= 0 && m_dir_we)
            check_output("mc_d", bus.mc_d, bus.req_d[m_owner*32 +: 32]);
      end
   end

   task automatic tick();
      @(posedge clk_mem);
      #1;
   endtask

   task automatic apply_stimulus(input int r, input bit we, input logic [21:0] a,
                                 input logic [31:0] d, input bit ben, input logic [7:0] len);
      bus.req_we[r]             = we;
      bus.req_a[r*22 +: 22]     = a;
      bus.req_d[r*32 +: 32]     = d;
      bus.req_burst_en[r]       = ben;
      bus.req_burst_len[r*8 +: 8] = len;
      bus.req[r]                = 1'b1;
   endtask

   task automatic wait_new_grant(output int idx);
      int n;
      n   = 0;
      idx = -1;
      while (bus.gnt != '0 && n < 40) begin tick(); n++; end
      while (bus.gnt == '0 && n < 40) begin tick(); n++; end
      if (bus.gnt == '0) begin
         checks++; errors++;
         $display("[TB] FAIL grant_wait actual=none expected=grant");
      end else begin
         for (int i = 0; i < N; i++) if (bus.gnt[i]) idx = i;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.gnt != '0 && n < 40) begin tick(); n++; end
      checks++;
      if (bus.gnt != '0) begin
         errors++;
         $display("[TB] FAIL idle_wait actual=%0b expected=0", bus.gnt);
      end
   endtask

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int idx;
      int order [6];
      bus.req = '0; bus.req_we = '0; bus.req_a = '0; bus.req_d = '0;
      bus.req_burst_en = '0; bus.req_burst_len = '0;
      bus.mc_ready = 1'b0; bus.mc_spo = '0;
      rst = 1'b1;
      tick(); tick();
      check_output("reset_gnt", bus.gnt, 3'b000);
      check_output("reset_mc_rd", bus.mc_rd, 1'b0);
      check_output("reset_mc_a", bus.mc_a, 22'h0);
      check_output("reset_blen", bus.mc_burst_length, 8'h0);
      rst = 1'b0;

      // Single read from requester 1
      apply_stimulus(1, 1'b0, 22'h00123, 32'h0, 1'b0, 8'd0);
      tick();
      check_output("t1_gnt", bus.gnt, 3'b010);
      check_output("t1_rd_early", bus.mc_rd, 1'b0);
      tick();
      check_output("t1_rd", bus.mc_rd, 1'b1);
      check_output("t1_a", bus.mc_a, 22'h00123);
      bus.mc_ready = 1'b1; bus.mc_spo = 32'hDEADBEEF;
      #1;
      check_output("t1_ready", bus.rsp_ready, 3'b010);
      check_output("t1_data", bus.rsp_data, 32'hDEADBEEF);
      tick();
      bus.mc_ready = 1'b0; bus.req[1] = 1'b0;
      check_output("t1_gap_gnt", bus.gnt, 3'b010);
      tick();
      check_output("t1_gap2_gnt", bus.gnt, 3'b010);
      tick();
      check_output("t1_idle_gnt", bus.gnt, 3'b000);

      // Burst write of four words from requester 0
      apply_stimulus(0, 1'b1, 22'h00200, 32'h1, 1'b1, 8'd4);
      wait_new_grant(idx);
      check_output("t2_grant", idx, 0);
      tick();
      check_output("t2_we", bus.mc_we, 1'b1);
      check_output("t2_ben", bus.mc_burst_en, 1'b1);
      for (int b = 0; b < 4; b++) begin
         bus.mc_ready = 1'b1;
         #1;
         check_output("t2_mc_d", bus.mc_d, 32'(b + 1));
         check_output("t2_ready", bus.rsp_ready, 3'b001);
         check_output("t2_blen", bus.mc_burst_length, 8'd4);
         tick();
         bus.mc_ready = 1'b0;
         bus.req_d[0 +: 32] = 32'(b + 2);
         if (b == 3) bus.req[0] = 1'b0;
         tick();
      end
      wait_idle();

      // Zero-length burst read consumes one beat; stray strobe in the gap
      apply_stimulus(0, 1'b0, 22'h00077, 32'h0, 1'b1, 8'd0);
      wait_new_grant(idx);
      check_output("t4_grant", idx, 0);
      tick();
      check_output("t4_blen", bus.mc_burst_length, 8'd1);
      bus.mc_ready = 1'b1; bus.mc_spo = 32'hCAFE0001;
      #1;
      check_output("t4_ready", bus.rsp_ready, 3'b001);
      tick();
      bus.req = '0;
      #1;
      check_output("t4_gap_ready", bus.rsp_ready, 3'b000);
      tick();
      bus.mc_ready = 1'b0;
      tick();
      check_output("t4_idle_gnt", bus.gnt, 3'b000);

      // Reset during the second beat of an 8-beat read burst
      apply_stimulus(1, 1'b0, 22'h3ABCD, 32'h0, 1'b1, 8'd8);
      wait_new_grant(idx);
      check_output("t5_grant", idx, 1);
      tick();
      bus.mc_ready = 1'b1; bus.mc_spo = 32'h11;
      tick();
      bus.mc_ready = 1'b0;
      tick();
      bus.mc_ready = 1'b1; bus.mc_spo = 32'h22; rst = 1'b1;
      tick();
      bus.mc_ready = 1'b0; bus.req = '0;
      #1;
      check_output("t5_rst_gnt", bus.gnt, 3'b000);
      check_output("t5_rst_a", bus.mc_a, 22'h0);
      check_output("t5_rst_blen", bus.mc_burst_length, 8'h0);
      check_output("t5_rst_ben", bus.mc_burst_en, 1'b0);
      check_output("t5_rst_ready", bus.rsp_ready, 3'b000);
      rst = 1'b0;
      apply_stimulus(0, 1'b0, 22'h00010, 32'h0, 1'b0, 8'd0);
      apply_stimulus(2, 1'b0, 22'h00020, 32'h0, 1'b0, 8'd0);
      tick();
      check_output("t5_ptr0_gnt", bus.gnt, 3'b001);
      tick();
      bus.mc_ready = 1'b1; bus.mc_spo = 32'h33;
      tick();
      bus.mc_ready = 1'b0; bus.req = '0;
      wait_idle();

      // All three requesting continuously from reset
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      for (int r = 0; r < N; r++) apply_stimulus(r, 1'b0, 22'(r * 16), 32'h0, 1'b0, 8'd0);
      for (int n = 0; n < 6; n++) begin
         wait_new_grant(idx);
         order[n] = idx;
         tick();
         bus.mc_ready = 1'b1; bus.mc_spo = 32'(n);
         tick();
         bus.mc_ready = 1'b0;
      end
      for (int n = 0; n < 6; n++) check_output("t3_order", order[n], n % 3);
      bus.req = '0;
      wait_idle();

`ifdef PSRAM_ARB_TIMEOUT_EN
      // No beat ever arrives: watchdog aborts the transfer
      apply_stimulus(2, 1'b0, 22'h00099, 32'h0, 1'b1, 8'd4);
      wait_new_grant(idx);
      check_output("t6_grant", idx, 2);
      tick();
      repeat (TO - 1) tick();
      check_output("t6_err_early", bus.rsp_err, 3'b000);
      tick();
      check_output("t6_err", bus.rsp_err, 3'b100);
      bus.req = '0;
      tick();
      check_output("t6_err_clear", bus.rsp_err, 3'b000);
      wait_idle();
`endif

      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
